// File: rtl/cache_controller.sv
// Direct-mapped write-through, no-write-allocate byte cache; latency read hit 1, write 2, read miss 3.
// One request in flight: cpu_ready is high only in IDLE and requests seen while busy are dropped.
module cache_controller #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 2 ** INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, FILL_WAIT, WRITE_MEM} state_t;

  state_t             state;
  logic               req_we;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               req_hit;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [DATA_W-1:0]  data_arr [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic               lookup_hit;
  logic               line_we;
  logic [DATA_W-1:0]  line_wdata;

  assign idx        = req_addr[INDEX_W-1:0];
  assign req_tag    = req_addr[ADDR_W-1:INDEX_W];
  assign lookup_hit = valid[idx] && (tag_arr[idx] == req_tag);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Line storage is written on a write hit (write-through update) or on fill completion.
  always_comb begin
    line_we    = 1'b0;
    line_wdata = req_wdata;
    if (state == LOOKUP && req_we && lookup_hit) begin
      line_we = 1'b1;
    end else if (state == FILL_WAIT) begin
      line_we    = 1'b1;
      line_wdata = mem_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_arr[idx]  <= req_tag;
      data_arr[idx] <= line_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_hit        <= 1'b0;
      valid          <= '0;
      cpu_ready      <= 1'b1;
      cpu_done       <= 1'b0;
      cpu_rdata      <= '0;
      cpu_hit        <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            cpu_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_hit) hit_count <= sat_inc(hit_count);
          else            miss_count <= sat_inc(miss_count);
          if (req_we) begin
            mem_write_en   <= 1'b1;
            mem_address    <= req_addr;
            mem_write_data <= req_wdata;
            req_hit        <= lookup_hit;
            state          <= WRITE_MEM;
          end else if (lookup_hit) begin
            cpu_rdata <= data_arr[idx];
            cpu_done  <= 1'b1;
            cpu_hit   <= 1'b1;
            cpu_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            mem_read_en <= 1'b1;
            mem_address <= req_addr;
            state       <= FILL;
          end
        end
        FILL: begin
          mem_read_en <= 1'b0;
          state       <= FILL_WAIT;
        end
        FILL_WAIT: begin
          valid[idx] <= 1'b1;
          cpu_rdata  <= mem_read_data;
          cpu_done   <= 1'b1;
          cpu_hit    <= 1'b0;
          cpu_ready  <= 1'b1;
          state      <= IDLE;
        end
        WRITE_MEM: begin
          mem_write_en <= 1'b0;
          cpu_done     <= 1'b1;
          cpu_hit      <= req_hit;
          cpu_ready    <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
